median_frame_ctrl: RTL and testbench

- Timing controller and sequencer for the 5x5 median-filter datapath, sitting between the HDMI receiver outputs and the kernel line buffer / median core / HDMI transmitter.
- Tracks frame geometry from rx_dv/rx_hs/rx_vs and drives line-buffer write enable, line rotation and column address.
- Delays sync/valid by the datapath latency and flags border pixels so the output mux can pass border pixels through unfiltered.
- Holds the datapath in pass-through until it has locked onto a stable frame size.

---
 rtl/median_pkg.sv | 16 +
 rtl/video_pos_counter.sv | 59 +++++
 rtl/median_frame_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_median_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants and FSM encoding for the median-filter frame controller.
package median_pkg;

  localparam int unsigned KSIZE_DEF = 5;
  localparam int unsigned HALF_DEF  = KSIZE_DEF / 2;
  localparam int unsigned CW_DEF    = 12;
  localparam int unsigned LAT_DEF   = 8;
  localparam int unsigned LSW       = $clog2(KSIZE_DEF);

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StMeasure = 2'd1,
    StLocked  = 2'd2
  } state_e;

endpackage

// File: rtl/video_pos_counter.sv
// Column/row position tracker for a dv/vs video stream.
// vs rising edge clears everything and wins over a coincident dv falling edge.
module video_pos_counter
  import median_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dv,
  input  logic          vs,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          dv_fall,
  output logic          vs_rise
);

  localparam logic [CW-1:0] CntMax = '1;

  logic          dv_q, vs_q;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;

  assign vs_rise = vs & ~vs_q;
  assign dv_fall = ~dv & dv_q;
  assign col     = col_q;
  assign row     = row_q;

  // Next column/row; both counters saturate instead of wrapping.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (vs_rise) begin
      col_d = '0;
      row_d = '0;
    end else if (dv_fall) begin
      col_d = '0;
      if (row_q != CntMax) row_d = row_q + CW'(1);
    end else if (dv && (col_q != CntMax)) begin
      col_d = col_q + CW'(1);
    end
  end

  // Edge-detect history and position registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dv_q  <= 1'b0;
      vs_q  <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      dv_q  <= dv;
      vs_q  <= vs;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/median_frame_ctrl.sv
// Frame timing controller for the 5x5 median datapath: line-buffer write
// sequencing, geometry lock FSM, sync delay line and border flagging.
module median_frame_ctrl
  import median_pkg::*;
#(
  parameter int unsigned KSIZE = KSIZE_DEF, // odd, 3..8 (line select is 3 bits)
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned LAT   = LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_dv,
  input  logic          rx_hs,
  input  logic          rx_vs,
  input  logic          bypass,
  output logic          buf_wr_en,
  output logic [CW-1:0] buf_col,
  output logic [2:0]    buf_line_sel,
  output logic          kernel_valid,
  output logic          tx_dv,
  output logic          tx_hs,
  output logic          tx_vs,
  output logic          tx_border,
  output logic          locked,
  output logic [CW-1:0] frame_w,
  output logic [CW-1:0] frame_h
);

  localparam int unsigned   HALF    = KSIZE / 2;
  localparam logic [CW-1:0] KLast   = CW'(KSIZE - 1);
  localparam logic [CW-1:0] KEdge   = CW'(KSIZE);
  localparam logic [CW-1:0] HalfC   = CW'(HALF);
  localparam logic [2:0]    SelLast = 3'(KSIZE - 1);

  logic [CW-1:0] wr_col, wr_row;
  logic          wr_dv_fall, wr_vs_rise;
  logic [CW-1:0] ox, oy;
  logic          out_dv_fall, out_vs_rise;

  logic [2:0]    line_sel_q, line_sel_d;
  state_e        state_q, state_d;
  logic [CW-1:0] w_q, w_d;
  logic          have_w_q, have_w_d;
  logic [CW-1:0] fw_q, fw_d;
  logic [CW-1:0] fh_q, fh_d;
  logic [LAT-1:0][2:0] dly_q;

  video_pos_counter #(.CW(CW)) u_wr_pos (
    .clk     (clk),
    .rst     (rst),
    .dv      (rx_dv),
    .vs      (rx_vs),
    .col     (wr_col),
    .row     (wr_row),
    .dv_fall (wr_dv_fall),
    .vs_rise (wr_vs_rise)
  );

  video_pos_counter #(.CW(CW)) u_out_pos (
    .clk     (clk),
    .rst     (rst),
    .dv      (tx_dv),
    .vs      (tx_vs),
    .col     (ox),
    .row     (oy),
    .dv_fall (out_dv_fall),
    .vs_rise (out_vs_rise)
  );

  // Write enable is zero-latency but held off while in reset.
  assign buf_wr_en    = rx_dv & rst;
  assign buf_col      = wr_col;
  assign buf_line_sel = line_sel_q;
  assign locked       = (state_q == StLocked);
  assign frame_w      = fw_q;
  assign frame_h      = fh_q;
  assign kernel_valid = locked & rx_dv & (wr_row >= KLast) & (wr_col >= KLast);
  assign {tx_dv, tx_hs, tx_vs} = dly_q[LAT-1];

  // Line rotation: advance per line, restart at frame start.
  always_comb begin
    line_sel_d = line_sel_q;
    if (wr_vs_rise) begin
      line_sel_d = '0;
    end else if (wr_dv_fall) begin
      line_sel_d = (line_sel_q == SelLast) ? 3'd0 : line_sel_q + 3'd1;
    end
  end

  // Geometry lock FSM. At dv_fall the column counter already holds the
  // pixel count of the finished line, so it is compared directly to width.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    have_w_d = have_w_q;
    fw_d     = fw_q;
    fh_d     = fh_q;
    case (state_q)
      StSearch: begin
        if (wr_vs_rise) begin
          state_d  = StMeasure;
          have_w_d = 1'b0;
        end
      end
      StMeasure: begin
        if (wr_vs_rise) begin
          if (wr_row == '0) begin
            state_d = StSearch;
          end else begin
            fw_d    = w_q;
            fh_d    = wr_row;
            state_d = StLocked;
          end
        end else if (wr_dv_fall) begin
          if (!have_w_q) begin
            w_d      = wr_col;
            have_w_d = 1'b1;
          end else if (wr_col != w_q) begin
            state_d = StSearch;
          end
        end
      end
      StLocked: begin
        if (wr_vs_rise) begin
          if (wr_row != fh_q) begin
            state_d  = StMeasure;
            have_w_d = 1'b0;
          end
        end else if (wr_dv_fall && (wr_col != fw_q)) begin
          state_d = StSearch;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Border flag; undersized geometry is all-border so the subtractions never wrap.
  always_comb begin
    tx_border = 1'b0;
    if (tx_dv) begin
      if (!locked || bypass || (fw_q < KEdge) || (fh_q < KEdge)) begin
        tx_border = 1'b1;
      end else begin
        tx_border = (ox < HalfC) || (ox >= fw_q - HalfC) ||
                    (oy < HalfC) || (oy >= fh_q - HalfC);
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_sel_q <= '0;
      state_q    <= StSearch;
      w_q        <= '0;
      have_w_q   <= 1'b0;
      fw_q       <= '0;
      fh_q       <= '0;
    end else begin
      line_sel_q <= line_sel_d;
      state_q    <= state_d;
      w_q        <= w_d;
      have_w_q   <= have_w_d;
      fw_q       <= fw_d;
      fh_q       <= fh_d;
    end
  end

  // Fixed-latency sync delay line matching the datapath; never stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= {rx_dv, rx_hs, rx_vs};
      for (int unsigned i = 1; i < LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Directed bench for median_frame_ctrl using 8x6 frames.
module tb_median_frame_ctrl;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_dv = 1'b0, rx_hs = 1'b0, rx_vs = 1'b0, bypass = 1'b0;
  logic        buf_wr_en, kernel_valid, tx_dv, tx_hs, tx_vs, tx_border, locked;
  logic [11:0] buf_col, frame_w, frame_h;
  logic [2:0]  buf_line_sel;

  median_frame_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rx_dv        (rx_dv),
    .rx_hs        (rx_hs),
    .rx_vs        (rx_vs),
    .bypass       (bypass),
    .buf_wr_en    (buf_wr_en),
    .buf_col      (buf_col),
    .buf_line_sel (buf_line_sel),
    .kernel_valid (kernel_valid),
    .tx_dv        (tx_dv),
    .tx_hs        (tx_hs),
    .tx_vs        (tx_vs),
    .tx_border    (tx_border),
    .locked       (locked),
    .frame_w      (frame_w),
    .frame_h      (frame_h)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dv;
    logic       hs;
    logic       vs;
    logic [7:0] x;
    logic [7:0] y;
  } ent_t;

  int   total = 0;
  int   bad = 0;
  ent_t q[$];
  logic exp_locked = 1'b0;
  logic chk_border = 1'b0;
  int   kv_cnt, kv_x, kv_y, b0_cnt, txdv_cnt;
  int   tx_err = 0, bd_err = 0, col_err = 0;
  logic [2:0] ls_seq [6];
  logic lk_line [6];
  logic lk_pre, lk_post;
  int   lat, pre_err;
  logic tx_at9;
  logic [2:0] exp_ls [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Interior of a locked 8x6 frame is cols 2..5, rows 2..3.
  function automatic logic exp_border(input logic [7:0] x, input logic [7:0] y);
    return !exp_locked || bypass || !(x >= 8'd2 && x <= 8'd5 && y >= 8'd2 && y <= 8'd3);
  endfunction

  // One clock of stimulus plus observation of this cycle's outputs.
  task automatic pix(input logic dv, input logic hs, input logic vs, input int x, input int y);
    ent_t e;
    ent_t o;
    rx_dv = dv;
    rx_hs = hs;
    rx_vs = vs;
    #2;
    if (dv) begin
      if (buf_wr_en !== 1'b1 || buf_col !== 12'(x)) col_err++;
      if (x == 0 && y < 6) ls_seq[y] = buf_line_sel;
    end else if (buf_wr_en !== 1'b0) begin
      col_err++;
    end
    if (kernel_valid === 1'b1) begin
      if (kv_cnt == 0) begin
        kv_x = x;
        kv_y = y;
      end
      kv_cnt++;
    end
    e.dv = dv;
    e.hs = hs;
    e.vs = vs;
    e.x  = 8'(x);
    e.y  = 8'(y);
    q.push_back(e);
    o = q.pop_front();
    if ({tx_dv, tx_hs, tx_vs} !== {o.dv, o.hs, o.vs}) tx_err++;
    if (tx_dv === 1'b1) begin
      txdv_cnt++;
      if (tx_border === 1'b0) b0_cnt++;
      if (chk_border && (tx_border !== exp_border(o.x, o.y))) bd_err++;
    end
    @(posedge clk);
    #1;
  endtask

  // vsync pulse, 6 lines of 8 (one line may be odd_w wide), hblank 4, tail blank.
  task automatic frame(input int odd_line, input int odd_w);
    int lw;
    kv_cnt   = 0;
    b0_cnt   = 0;
    txdv_cnt = 0;
    kv_x     = -1;
    kv_y     = -1;
    lk_pre   = locked;
    pix(1'b0, 1'b0, 1'b1, 0, 0);
    lk_post = locked;
    pix(1'b0, 1'b0, 1'b1, 0, 0);
    pix(1'b0, 1'b0, 1'b0, 0, 0);
    pix(1'b0, 1'b0, 1'b0, 0, 0);
    for (int y = 0; y < 6; y++) begin
      lw = (y == odd_line) ? odd_w : 8;
      for (int x = 0; x < lw; x++) pix(1'b1, 1'b0, 1'b0, x, y);
      pix(1'b0, 1'b1, 1'b0, 0, 0);
      lk_line[y] = locked;
      pix(1'b0, 1'b1, 1'b0, 0, 0);
      pix(1'b0, 1'b0, 1'b0, 0, 0);
      pix(1'b0, 1'b0, 1'b0, 0, 0);
    end
    repeat (12) pix(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    // Reset with random input activity.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_dv = 1'($urandom);
      rx_hs = 1'($urandom);
      rx_vs = 1'($urandom);
      @(posedge clk);
      #1;
      check("reset_ctl", 32'({buf_wr_en, buf_line_sel, kernel_valid, tx_dv, tx_hs, tx_vs,
                              tx_border, locked}), 32'd0);
      check("reset_geom", 32'({buf_col, frame_w}), 32'd0);
      check("reset_fh", 32'(frame_h), 32'd0);
    end

    // Release with a single-cycle dv pulse; measure its output latency.
    rst   = 1'b1;
    rx_dv = 1'b1;
    rx_hs = 1'b0;
    rx_vs = 1'b0;
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
    lat     = -1;
    pre_err = 0;
    tx_at9  = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      if (lat < 0) begin
        if (tx_dv === 1'b1) lat = k;
        else if ({tx_dv, tx_hs, tx_vs} !== 3'b000) pre_err++;
      end
      if (k == 9) tx_at9 = tx_dv;
      @(posedge clk);
      #1;
    end
    check("latency", 32'(lat), 32'd8);
    check("tx_quiet_after_release", 32'(pre_err), 32'd0);
    check("pulse_width", 32'(tx_at9), 32'd0);

    q.delete();
    repeat (LAT) q.push_back('0);

    // Frame 1: measured, not yet locked.
    exp_locked = 1'b0;
    chk_border = 1'b1;
    frame(-1, 0);
    check("f1_locked_after_vs", 32'(lk_post), 32'd0);
    check("f1_kv_cnt", 32'(kv_cnt), 32'd0);
    check("f1_b0_cnt", 32'(b0_cnt), 32'd0);

    // Frame 2: locks at its vs_rise.
    exp_locked = 1'b1;
    frame(-1, 0);
    check("f2_locked_before_vs", 32'(lk_pre), 32'd0);
    check("f2_locked_after_vs", 32'(lk_post), 32'd1);
    check("f2_frame_w", 32'(frame_w), 32'd8);
    check("f2_frame_h", 32'(frame_h), 32'd6);
    check("f2_kv_cnt", 32'(kv_cnt), 32'd8);
    check("f2_kv_first_x", 32'(kv_x), 32'd4);
    check("f2_kv_first_y", 32'(kv_y), 32'd4);
    for (int y = 0; y < 6; y++) check($sformatf("f2_line_sel_%0d", y), 32'(ls_seq[y]),
                                      32'(exp_ls[y]));
    check("f2_b0_cnt", 32'(b0_cnt), 32'd8);
    check("f2_txdv_cnt", 32'(txdv_cnt), 32'd48);

    // Frame 3: stays locked.
    frame(-1, 0);
    check("f3_locked_before_vs", 32'(lk_pre), 32'd1);
    check("f3_b0_cnt", 32'(b0_cnt), 32'd8);

    // Geometry change: line 2 only 7 wide.
    chk_border = 1'b0;
    frame(2, 7);
    check("geo_locked_line1", 32'(lk_line[1]), 32'd1);
    check("geo_locked_line2", 32'(lk_line[2]), 32'd0);
    check("geo_b0_cnt", 32'(b0_cnt), 32'd0);
    check("geo_txdv_cnt", 32'(txdv_cnt), 32'd47);
    check("geo_frame_w_kept", 32'(frame_w), 32'd8);

    // Two clean frames to relock.
    exp_locked = 1'b0;
    chk_border = 1'b1;
    frame(-1, 0);
    check("relock_a_locked", 32'(lk_post), 32'd0);
    check("relock_a_b0_cnt", 32'(b0_cnt), 32'd0);
    exp_locked = 1'b1;
    frame(-1, 0);
    check("relock_b_locked", 32'(lk_post), 32'd1);
    check("relock_b_b0_cnt", 32'(b0_cnt), 32'd8);

    // Bypass forces every output pixel to border.
    bypass = 1'b1;
    frame(-1, 0);
    check("byp_b0_cnt", 32'(b0_cnt), 32'd0);
    check("byp_txdv_cnt", 32'(txdv_cnt), 32'd48);
    check("byp_kv_cnt", 32'(kv_cnt), 32'd8);
    bypass = 1'b0;

    // vs_rise coinciding with dv_fall: vs wins.
    chk_border = 1'b0;
    check("line_sel_after_6_lines", 32'(buf_line_sel), 32'd1);
    for (int x = 0; x < 8; x++) pix(1'b1, 1'b0, 1'b0, x, 0);
    pix(1'b0, 1'b0, 1'b1, 0, 0);
    check("vs_beats_dvfall_sel", 32'(buf_line_sel), 32'd0);
    check("vs_beats_dvfall_locked", 32'(locked), 32'd1);
    pix(1'b0, 1'b0, 1'b0, 0, 0);
    for (int x = 0; x < 3; x++) pix(1'b1, 1'b0, 1'b0, x, 0);

    check("wr_side_errs", 32'(col_err), 32'd0);
    check("tx_delay_errs", 32'(tx_err), 32'd0);
    check("border_errs", 32'(bd_err), 32'd0);

    // Reset mid-line discards geometry.
    rst   = 1'b0;
    rx_dv = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_locked", 32'(locked), 32'd0);
    check("midreset_frame", 32'({frame_w, frame_h}), 32'd0);
    check("midreset_wr", 32'({buf_wr_en, buf_line_sel}), 32'd0);
    rst   = 1'b1;
    rx_dv = 1'b0;
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
